// File: rtl/sirv_gnrl_skidbuf_pkg.sv
// Shared types and helpers for the two-entry valid/ready skid buffer.
// The occupancy encoding is 2 bits wide; value 3 is unused.
package sirv_gnrl_skidbuf_pkg;

   localparam int unsigned CNT_W = 2;

   typedef enum logic [CNT_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } cnt_e;

   function automatic logic cnt_has_data(input cnt_e c);
      return (c != EMPTY);
   endfunction

   function automatic logic cnt_has_room(input cnt_e c);
      return (c != FULL);
   endfunction

endpackage

// File: rtl/sirv_gnrl_skidbuf_if.sv
// Valid/ready payload channel. The producer side uses the master modport
// and the consumer side uses the slave modport.
interface sirv_gnrl_skidbuf_if #(
   parameter int DW = 32
) ();
   logic          vld;
   logic          rdy;
   logic [DW-1:0] dat;

   modport master (output vld, output dat, input  rdy);
   modport slave  (input  vld, input  dat, output rdy);
endinterface

// File: rtl/sirv_gnrl_dfflr.sv
// General DFF cell: asynchronous active-low reset to zero, load-enabled update.
module sirv_gnrl_dfflr #(
   parameter int DW = 32
) (
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout,
   input  logic          clk,
   input  logic          rst_n
);
   logic [DW-1:0] qout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout_q <= '0;
      end else if (lden) begin
         qout_q <= dnxt;
      end
   end

   assign qout = qout_q;
endmodule

// File: rtl/sirv_gnrl_dfflrs.sv
// General DFF cell: asynchronous active-low reset to all-ones (set-type), load-enabled update.
module sirv_gnrl_dfflrs #(
   parameter int DW = 32
) (
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout,
   input  logic          clk,
   input  logic          rst_n
);
   logic [DW-1:0] qout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout_q <= '1;
      end else if (lden) begin
         qout_q <= dnxt;
      end
   end

   assign qout = qout_q;
endmodule

// File: rtl/sirv_gnrl_skidbuf.sv
// Two-entry valid/ready skid buffer: main reg drives o.dat, skid reg holds the second entry.
// o.vld and i.rdy both come straight from flops, so no combinational path crosses the block.
module sirv_gnrl_skidbuf
   import sirv_gnrl_skidbuf_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   sirv_gnrl_skidbuf_if.slave  i,
   sirv_gnrl_skidbuf_if.master o
);
   logic [CNT_W-1:0] cnt_raw;
   cnt_e             cnt_q;
   cnt_e             cnt_d;
   logic             cnt_ld;
   logic             vld_q;
   logic             vld_d;
   logic             rdy_q;
   logic             rdy_d;
   logic             main_ld;
   logic             skid_ld;
   logic             in_hs;
   logic             out_hs;
   logic [DW-1:0]    main_d;
   logic [DW-1:0]    main_q;
   logic [DW-1:0]    skid_q;

   assign cnt_q  = cnt_e'(cnt_raw);
   assign in_hs  = i.vld & rdy_q;
   assign out_hs = vld_q & o.rdy;

   always_comb begin
      cnt_d   = cnt_q;
      cnt_ld  = 1'b0;
      main_ld = 1'b0;
      main_d  = i.dat;
      skid_ld = 1'b0;
      case (cnt_q)
         EMPTY: begin
            if (in_hs) begin
               main_ld = 1'b1;
               cnt_d   = ONE;
               cnt_ld  = 1'b1;
            end
         end
         ONE: begin
            if (in_hs && out_hs) begin
               main_ld = 1'b1;
            end else if (in_hs) begin
               skid_ld = 1'b1;
               cnt_d   = FULL;
               cnt_ld  = 1'b1;
            end else if (out_hs) begin
               cnt_d   = EMPTY;
               cnt_ld  = 1'b1;
            end
         end
         FULL: begin
            if (out_hs) begin
               main_ld = 1'b1;
               main_d  = skid_q;
               cnt_d   = ONE;
               cnt_ld  = 1'b1;
            end
         end
         default: begin
            cnt_d  = EMPTY;
            cnt_ld = 1'b1;
         end
      endcase
   end

   // Flags are recomputed from the next occupancy and load together with cnt.
   assign vld_d = cnt_has_data(cnt_d);
   assign rdy_d = cnt_has_room(cnt_d);

   sirv_gnrl_dfflr #(.DW(CNT_W)) u_cnt (
      .lden (cnt_ld),
      .dnxt (cnt_d),
      .qout (cnt_raw),
      .clk  (clk),
      .rst_n(rst_n)
   );

   sirv_gnrl_dfflr #(.DW(1)) u_vld (
      .lden (cnt_ld),
      .dnxt (vld_d),
      .qout (vld_q),
      .clk  (clk),
      .rst_n(rst_n)
   );

   sirv_gnrl_dfflrs #(.DW(1)) u_rdy (
      .lden (cnt_ld),
      .dnxt (rdy_d),
      .qout (rdy_q),
      .clk  (clk),
      .rst_n(rst_n)
   );

   sirv_gnrl_dfflr #(.DW(DW)) u_main (
      .lden (main_ld),
      .dnxt (main_d),
      .qout (main_q),
      .clk  (clk),
      .rst_n(rst_n)
   );

   sirv_gnrl_dfflr #(.DW(DW)) u_skid (
      .lden (skid_ld),
      .dnxt (i.dat),
      .qout (skid_q),
      .clk  (clk),
      .rst_n(rst_n)
   );

   assign i.rdy = rdy_q;
   assign o.vld = vld_q;
   assign o.dat = main_q;
endmodule

// File: tb/tb_sirv_gnrl_skidbuf.sv
// Scoreboard bench for sirv_gnrl_skidbuf: accepted payloads queue up and must leave in order;
// occupancy flags are checked every cycle against the queue depth.
module tb_sirv_gnrl_skidbuf;
   logic clk;
   logic rst_n;
   logic mon_en;

   int unsigned n_vec;
   int unsigned n_err;
   logic [31:0] sb_q[$];

   sirv_gnrl_skidbuf_if #(.DW(32)) in_if ();
   sirv_gnrl_skidbuf_if #(.DW(32)) out_if ();

   sirv_gnrl_skidbuf #(.DW(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .i    (in_if),
      .o    (out_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Handshakes are decided by values stable at the falling edge before the rising edge.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("o_vld", {31'b0, out_if.vld}, {31'b0, (sb_q.size() != 0)});
         chk("i_rdy", {31'b0, in_if.rdy},  {31'b0, (sb_q.size() < 2)});
         if (sb_q.size() != 0) chk("o_dat", out_if.dat, sb_q[0]);
         if (out_if.vld && out_if.rdy) begin
            chk("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
         end
         if (in_if.vld && in_if.rdy) sb_q.push_back(in_if.dat);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      logic hs;
      hs = 1'b0;
      in_if.vld = 1'b1;
      in_if.dat = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         hs = in_if.rdy;
         @(posedge clk);
         #1;
         if (hs) break;
      end
      if (!hs) chk("send_timeout", 32'd0, 32'd1);
      in_if.vld = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic hs;
      n_vec = 0;
      n_err = 0;
      mon_en = 1'b0;
      rst_n = 1'b0;
      in_if.vld = 1'b0;
      in_if.dat = '0;
      out_if.rdy = 1'b0;

      // Reset values while held and on the first cycle after release.
      repeat (2) @(negedge clk);
      chk("rst_i_rdy", {31'b0, in_if.rdy}, 32'd1);
      chk("rst_o_vld", {31'b0, out_if.vld}, 32'd0);
      chk("rst_o_dat", out_if.dat, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("post_rst_i_rdy", {31'b0, in_if.rdy}, 32'd1);
      chk("post_rst_o_dat", out_if.dat, 32'd0);
      @(posedge clk); #1;

      // Streaming at full rate.
      out_if.rdy = 1'b1;
      send(32'h11);
      send(32'h22);
      send(32'h33);
      cycles(3);

      // Backpressure fills both entries.
      out_if.rdy = 1'b0;
      send(32'hA);
      send(32'hB);
      @(negedge clk);
      chk("bp_i_rdy", {31'b0, in_if.rdy}, 32'd0);
      chk("bp_o_dat", out_if.dat, 32'hA);
      @(posedge clk); #1;
      out_if.rdy = 1'b1;
      cycles(3);
      @(negedge clk);
      chk("bp_drain_rdy", {31'b0, in_if.rdy}, 32'd1);
      chk("bp_drain_vld", {31'b0, out_if.vld}, 32'd0);
      @(posedge clk); #1;

      // Simultaneous in/out while holding one entry.
      out_if.rdy = 1'b0;
      send(32'h5);
      out_if.rdy = 1'b1;
      send(32'h6);
      out_if.rdy = 1'b0;
      @(negedge clk);
      chk("sim_o_dat", out_if.dat, 32'h6);
      chk("sim_o_vld", {31'b0, out_if.vld}, 32'd1);
      chk("sim_i_rdy", {31'b0, in_if.rdy}, 32'd1);
      @(posedge clk); #1;
      out_if.rdy = 1'b1;
      cycles(3);

      // Asynchronous reset while full.
      out_if.rdy = 1'b0;
      send(32'h1);
      send(32'h2);
      @(negedge clk);
      chk("full_i_rdy", {31'b0, in_if.rdy}, 32'd0);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_o_vld", {31'b0, out_if.vld}, 32'd0);
      chk("arst_i_rdy", {31'b0, in_if.rdy}, 32'd1);
      chk("arst_o_dat", out_if.dat, 32'd0);
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      out_if.rdy = 1'b1;
      cycles(4);
      send(32'h77);
      cycles(3);

      // Random traffic obeying the producer hold rule.
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         hs = in_if.vld & in_if.rdy;
         @(posedge clk); #1;
         if (hs || !in_if.vld) begin
            in_if.vld = 1'($urandom_range(0, 1));
            in_if.dat = $urandom;
         end
         out_if.rdy = (c < 5000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      end
      out_if.rdy = 1'b1;
      hs = !in_if.vld;
      for (int k = 0; k < 10 && !hs; k++) begin
         @(negedge clk);
         hs = in_if.vld & in_if.rdy;
         @(posedge clk); #1;
      end
      if (!hs) chk("final_send_timeout", 32'd0, 32'd1);
      in_if.vld = 1'b0;
      cycles(5);
      chk("drain_empty", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
